// File: rtl/key_conditioner.sv
// Synchronises and debounces active-low push-buttons into clean pressed levels plus press/release pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from a clean input step; no backpressure, outputs are free-running levels/pulses.
module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] Keys_n,
    output logic [NUM_KEYS-1:0] Pressed,
    output logic [NUM_KEYS-1:0] Press_pulse,
    output logic [NUM_KEYS-1:0] Release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   pressed_q;
        logic                   press_q;
        logic                   release_q;
        logic                   sample;

        // Last synchroniser stage, inverted so that 1 means the key is held.
        assign sample = ~sync_q[SYNC_STAGES-1];

        always_ff @(posedge Clk) begin
            if (!Reset) begin
                sync_q    <= '1;
                cnt_q     <= '0;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], Keys_n[i]};
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (sample == pressed_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Stable for DEBOUNCE_CYCLES cycles: accept the new level.
                    pressed_q <= sample;
                    press_q   <= sample;
                    release_q <= ~sample;
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign Pressed[i]       = pressed_q;
        assign Press_pulse[i]   = press_q;
        assign Release_pulse[i] = release_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboarded bench for key_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, NUM_KEYS=2.
module tb_key_conditioner;

    localparam int NK  = 2;
    localparam int DB  = 4;
    localparam int SS  = 2;
    localparam int LAT = SS + DB;

    logic          Clk;
    logic          Reset;
    logic [NK-1:0] Keys_n;
    logic [NK-1:0] Pressed;
    logic [NK-1:0] Press_pulse;
    logic [NK-1:0] Release_pulse;

    typedef struct {
        int            scen;
        logic [NK-1:0] pressed;
        logic [NK-1:0] pp;
        logic [NK-1:0] rp;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB),
        .SYNC_STAGES    (SS)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Keys_n       (Keys_n),
        .Pressed      (Pressed),
        .Press_pulse  (Press_pulse),
        .Release_pulse(Release_pulse)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input int scen, input logic [31:0] got,
                            input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s scen %0d cyc %0d got %0h expected %0h", tag, scen, cyc, got, want);
        end
    endtask

    // Every expectation pushed before an edge is compared just after that edge.
    always @(posedge Clk) begin
        cyc++;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("pressed",       e.scen, 32'(Pressed),       32'(e.pressed));
            check_eq("press_pulse",   e.scen, 32'(Press_pulse),   32'(e.pp));
            check_eq("release_pulse", e.scen, 32'(Release_pulse), 32'(e.rp));
        end
    end

    task automatic step(input int scen, input logic rst_n, input logic [NK-1:0] keys,
                        input logic [NK-1:0] ep, input logic [NK-1:0] epp,
                        input logic [NK-1:0] erp);
        exp_t x;
        @(negedge Clk);
        Reset  = rst_n;
        Keys_n = keys;
        x.scen    = scen;
        x.pressed = ep;
        x.pp      = epp;
        x.rp      = erp;
        exp_q.push_back(x);
    endtask

    initial begin
        Reset  = 1'b0;
        Keys_n = 2'b00;

        // 0: reset held with keys pressed, outputs stay low
        for (int j = 1; j <= 3; j++) step(0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

        // 1: idle, then clean press of key 0
        for (int j = 1; j <= 3; j++) step(1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
        for (int j = 1; j <= 10; j++)
            step(1, 1'b1, 2'b10, (j >= LAT) ? 2'b01 : 2'b00, (j == LAT) ? 2'b01 : 2'b00, 2'b00);
        for (int j = 1; j <= 10; j++)
            step(1, 1'b1, 2'b11, (j >= LAT) ? 2'b00 : 2'b01, 2'b00, (j == LAT) ? 2'b01 : 2'b00);

        // 2: bounce shorter than the debounce window is rejected
        for (int j = 1; j <= 8; j++)
            step(2, 1'b1, (j % 2 == 1) ? 2'b10 : 2'b11, 2'b00, 2'b00, 2'b00);
        for (int j = 1; j <= 8; j++) step(2, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);

        // 3: bounce 0,1,0 then settle; pulse 6 edges after the final fall (edge 3 -> edge 8)
        for (int j = 1; j <= 12; j++)
            step(3, 1'b1, (j == 2) ? 2'b11 : 2'b10, (j >= 3 + LAT - 1) ? 2'b01 : 2'b00,
                 (j == 3 + LAT - 1) ? 2'b01 : 2'b00, 2'b00);
        for (int j = 1; j <= 10; j++)
            step(3, 1'b1, 2'b11, (j >= LAT) ? 2'b00 : 2'b01, 2'b00, (j == LAT) ? 2'b01 : 2'b00);

        // 4: both keys together, then release key 1 alone, then key 0
        for (int j = 1; j <= 10; j++)
            step(4, 1'b1, 2'b00, (j >= LAT) ? 2'b11 : 2'b00, (j == LAT) ? 2'b11 : 2'b00, 2'b00);
        for (int j = 1; j <= 10; j++)
            step(4, 1'b1, 2'b10, (j >= LAT) ? 2'b01 : 2'b11, 2'b00, (j == LAT) ? 2'b10 : 2'b00);
        for (int j = 1; j <= 10; j++)
            step(4, 1'b1, 2'b11, (j >= LAT) ? 2'b00 : 2'b01, 2'b00, (j == LAT) ? 2'b01 : 2'b00);

        // 5: reset pulse mid-debounce with key 0 held; press accepted 6 edges after reset ends
        for (int j = 1; j <= 3; j++) step(5, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
        step(5, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
        for (int j = 1; j <= 10; j++)
            step(5, 1'b1, 2'b10, (j >= LAT) ? 2'b01 : 2'b00, (j == LAT) ? 2'b01 : 2'b00, 2'b00);
        for (int j = 1; j <= 10; j++)
            step(5, 1'b1, 2'b11, (j >= LAT) ? 2'b00 : 2'b01, 2'b00, (j == LAT) ? 2'b01 : 2'b00);

        @(negedge Clk);
        @(negedge Clk);
        check_eq("drain", 6, 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
